ir_prefetch_queue: RTL and testbench

- Parametrised successor to the Gumnut instruction register.
- Sits between the instruction-memory bus and the control unit.
- Issues fetch requests, keeps a PC, buffers up to DEPTH fetched instructions and decodes the head entry into Gumnut fields.
- Supports pipeline flush on branch/jump. A stale in-flight fetch is discarded after a flush.

---
 rtl/gumnut_ir_pkg.sv | 55 +++++
 rtl/ir_fifo.sv | 52 +++++
 rtl/ir_prefetch_queue.sv | 114 +++++++++++
 tb/tb_ir_prefetch_queue.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/gumnut_ir_pkg.sv
// Gumnut instruction field positions, the decoded-field record and the shared decoder
// used by ir_prefetch_queue.
package gumnut_ir_pkg;

    localparam int GUMNUT_W   = 18;
    localparam int OP_HI      = 17;
    localparam int OP_LO      = 14;
    localparam int FN_HI      = 16;
    localparam int FN_LO      = 14;
    localparam int FN_ALT_HI  = 2;
    localparam int FN_ALT_LO  = 0;
    localparam int RD_HI      = 13;
    localparam int RD_LO      = 11;
    localparam int RS_HI      = 10;
    localparam int RS_LO      = 8;
    localparam int RS2_HI     = 7;
    localparam int RS2_LO     = 5;
    localparam int IMM_HI     = 7;
    localparam int IMM_LO     = 0;
    localparam int ADDR_HI    = 11;
    localparam int ADDR_LO    = 0;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  func;
        logic [2:0]  rs;
        logic [2:0]  rs2;
        logic [2:0]  rd;
        logic [2:0]  count;
        logic [7:0]  immed;
        logic [7:0]  offset;
        logic [7:0]  disp;
        logic [11:0] addr;
    } ir_fields_t;

    // ALU-register forms (bit 17 set) carry func in the low bits instead of next to the opcode.
    function automatic ir_fields_t decode_inst(input logic valid, input logic [GUMNUT_W-1:0] inst);
        ir_fields_t f;
        f = '0;
        if (valid) begin
            f.op     = {3'b000, inst[OP_HI:OP_LO]};
            f.func   = inst[OP_HI] ? inst[FN_ALT_HI:FN_ALT_LO] : inst[FN_HI:FN_LO];
            f.rs     = inst[RS_HI:RS_LO];
            f.rs2    = inst[RS2_HI:RS2_LO];
            f.rd     = inst[RD_HI:RD_LO];
            f.count  = inst[RS2_HI:RS2_LO];
            f.immed  = inst[IMM_HI:IMM_LO];
            f.offset = inst[IMM_HI:IMM_LO];
            f.disp   = inst[IMM_HI:IMM_LO];
            f.addr   = inst[ADDR_HI:ADDR_LO];
        end
        return f;
    endfunction

endpackage

// File: rtl/ir_fifo.sv
// Circular instruction buffer for ir_prefetch_queue: DEPTH words, head always visible,
// synchronous clear for pipeline flush.
module ir_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointer wrap is plain binary overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ir_prefetch_queue.sv
// Prefetching Gumnut instruction register: PC, single outstanding fetch, DEPTH-entry queue,
// flush with stale-fetch drop, combinational head decode. Optional macro: IR_BYPASS_EN.
module ir_prefetch_queue
    import gumnut_ir_pkg::*;
#(
    parameter int INST_W = 18,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    output logic [ADDR_W-1:0]          inst_adr_o,
    output logic                       inst_req_o,
    input  logic                       ack_i,
    input  logic [INST_W-1:0]          inst_i,
    output logic                       valid_o,
    input  logic                       take_i,
    input  logic                       flush_i,
    input  logic [ADDR_W-1:0]          flush_addr_i,
    output logic [6:0]                 op_o,
    output logic [2:0]                 func_o,
    output logic [2:0]                 rs_o,
    output logic [2:0]                 rs2_o,
    output logic [2:0]                 rd_o,
    output logic [2:0]                 count_o,
    output logic [7:0]                 immed_o,
    output logic [7:0]                 offset_o,
    output logic [7:0]                 disp_o,
    output logic [11:0]                addr_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [ADDR_W-1:0] pc;
    logic              drop;
    logic [LVL_W-1:0]  count;
    logic [INST_W-1:0] fifo_head;
    logic [INST_W-1:0] head;
    logic              empty;
    logic              accept;
    logic              push;
    logic              fifo_push;
    logic              fifo_pop;
    ir_fields_t        fields;

    assign empty      = (count == '0);
    assign inst_req_o = !rst_i && ((count < FULL_LVL) || drop);
    assign accept     = ack_i && inst_req_o;
    assign push       = accept && !drop && !flush_i;
    assign fifo_pop   = take_i && !empty && !flush_i;

`ifdef IR_BYPASS_EN
    logic bypass;
    // An empty queue forwards the arriving word directly; if it is taken at once it never lands.
    assign bypass    = empty && push;
    assign valid_o   = !empty || bypass;
    assign head      = empty ? inst_i : fifo_head;
    assign fifo_push = push && !(bypass && take_i);
`else
    assign valid_o   = !empty;
    assign head      = fifo_head;
    assign fifo_push = push;
`endif

    ir_fifo #(
        .WIDTH (INST_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clear (flush_i),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (inst_i),
        .head  (fifo_head),
        .count (count)
    );

    // drop marks that the fetch in flight at a flush belongs to the old stream.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc   <= '0;
            drop <= 1'b0;
        end else if (flush_i) begin
            pc   <= flush_addr_i;
            drop <= drop || (inst_req_o && !ack_i);
        end else begin
            if (push) begin
                pc <= pc + 1'b1;
            end
            if (drop && accept) begin
                drop <= 1'b0;
            end
        end
    end

    assign inst_adr_o = pc;
    assign level_o    = count;

    assign fields   = decode_inst(valid_o, head[GUMNUT_W-1:0]);
    assign op_o     = fields.op;
    assign func_o   = fields.func;
    assign rs_o     = fields.rs;
    assign rs2_o    = fields.rs2;
    assign rd_o     = fields.rd;
    assign count_o  = fields.count;
    assign immed_o  = fields.immed;
    assign offset_o = fields.offset;
    assign disp_o   = fields.disp;
    assign addr_o   = fields.addr;

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Directed bench for ir_prefetch_queue: scoreboard queue of accepted words checked against
// the decoded head; covers reset, fill/stall, func mux, push+pop, flush/drop, PC wrap.
module tb_ir_prefetch_queue;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [11:0] inst_adr_o;
    logic        inst_req_o;
    logic        ack_i;
    logic [17:0] inst_i;
    logic        valid_o;
    logic        take_i;
    logic        flush_i;
    logic [11:0] flush_addr_i;
    logic [6:0]  op_o;
    logic [2:0]  func_o, rs_o, rs2_o, rd_o, count_o;
    logic [7:0]  immed_o, offset_o, disp_o;
    logic [11:0] addr_o;
    logic [1:0]  level_o;

    int compared   = 0;
    int mismatched = 0;
    logic [17:0] exp_q[$];

    ir_prefetch_queue #(.INST_W(18), .ADDR_W(12), .DEPTH(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .inst_adr_o(inst_adr_o), .inst_req_o(inst_req_o),
        .ack_i(ack_i), .inst_i(inst_i), .valid_o(valid_o), .take_i(take_i),
        .flush_i(flush_i), .flush_addr_i(flush_addr_i), .op_o(op_o), .func_o(func_o),
        .rs_o(rs_o), .rs2_o(rs2_o), .rd_o(rd_o), .count_o(count_o), .immed_o(immed_o),
        .offset_o(offset_o), .disp_o(disp_o), .addr_o(addr_o), .level_o(level_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_inputs(input logic ack, input logic [17:0] inst, input logic take,
                              input logic flush, input logic [11:0] faddr);
        ack_i        = ack;
        inst_i       = inst;
        take_i       = take;
        flush_i      = flush;
        flush_addr_i = faddr;
    endtask

    // One clock with the given inputs, then inputs idle and outputs settled for checking.
    task automatic step(input logic ack, input logic [17:0] inst, input logic take,
                        input logic flush, input logic [11:0] faddr);
        set_inputs(ack, inst, take, flush, faddr);
        @(posedge clk_i);
        #1;
        set_inputs(1'b0, 18'h0, 1'b0, 1'b0, 12'h0);
        #1;
    endtask

    task automatic check_head(input string tag);
        logic [17:0] w;
        if (exp_q.size() == 0) begin
            check({tag, ".valid"}, 32'(valid_o), 32'd0);
            check({tag, ".op"},    32'(op_o),    32'd0);
            check({tag, ".addr"},  32'(addr_o),  32'd0);
            check({tag, ".immed"}, 32'(immed_o), 32'd0);
            check({tag, ".rd"},    32'(rd_o),    32'd0);
        end else begin
            w = exp_q[0];
            check({tag, ".valid"},  32'(valid_o),  32'd1);
            check({tag, ".op"},     32'(op_o),     32'({3'b000, w[17:14]}));
            check({tag, ".func"},   32'(func_o),   32'(w[17] ? w[2:0] : w[16:14]));
            check({tag, ".rs"},     32'(rs_o),     32'(w[10:8]));
            check({tag, ".rs2"},    32'(rs2_o),    32'(w[7:5]));
            check({tag, ".rd"},     32'(rd_o),     32'(w[13:11]));
            check({tag, ".count"},  32'(count_o),  32'(w[7:5]));
            check({tag, ".immed"},  32'(immed_o),  32'(w[7:0]));
            check({tag, ".offset"}, 32'(offset_o), 32'(w[7:0]));
            check({tag, ".disp"},   32'(disp_o),   32'(w[7:0]));
            check({tag, ".addr"},   32'(addr_o),   32'(w[11:0]));
        end
    endtask

    initial begin
        rst_i = 1'b1;
        set_inputs(1'b0, 18'h0, 1'b0, 1'b0, 12'h0);
        repeat (3) @(posedge clk_i);
        #1;
        check("rst.req",   32'(inst_req_o), 32'd0);
        check("rst.level", 32'(level_o),    32'd0);
        check_head("rst");

        rst_i = 1'b0;
        #1;
        check("idle.req", 32'(inst_req_o), 32'd1);
        check("idle.adr", 32'(inst_adr_o), 32'h000);

        // fill to full, no take
        step(1'b1, 18'h0A5C3, 1'b0, 1'b0, 12'h0); exp_q.push_back(18'h0A5C3);
        step(1'b1, 18'h2F001, 1'b0, 1'b0, 12'h0); exp_q.push_back(18'h2F001);
        check("fill.level", 32'(level_o),    32'd2);
        check("fill.req",   32'(inst_req_o), 32'd0);
        check("fill.adr",   32'(inst_adr_o), 32'h002);
        check_head("fill");

        // at full the request is low, so the ack is ignored and only the take lands
        step(1'b1, 18'h12345, 1'b1, 1'b0, 12'h0); void'(exp_q.pop_front());
        check("full_take.level", 32'(level_o),    32'd1);
        check("full_take.adr",   32'(inst_adr_o), 32'h002);
        check_head("full_take");

        // push and pop together at one entry
        step(1'b1, 18'h20007, 1'b1, 1'b0, 12'h0);
        void'(exp_q.pop_front()); exp_q.push_back(18'h20007);
        check("pushpop.level", 32'(level_o),    32'd1);
        check("pushpop.adr",   32'(inst_adr_o), 32'h003);
        check("func_alt.op",   32'(op_o),       32'h08);
        check("func_alt.func", 32'(func_o),     32'd7);
        check_head("pushpop");

        step(1'b0, 18'h0, 1'b1, 1'b0, 12'h0); void'(exp_q.pop_front());
        check("drain.level", 32'(level_o), 32'd0);
        check_head("drain");
        step(1'b0, 18'h0, 1'b1, 1'b0, 12'h0);
        check("empty_take.level", 32'(level_o), 32'd0);

        step(1'b1, 18'h0C000, 1'b0, 1'b0, 12'h0); exp_q.push_back(18'h0C000);
        check("func_std.func", 32'(func_o), 32'd3);
        check_head("func_std");
        step(1'b1, 18'h11111, 1'b0, 1'b0, 12'h0); exp_q.push_back(18'h11111);
        check("refill.level", 32'(level_o),    32'd2);
        check("refill.adr",   32'(inst_adr_o), 32'h005);
        step(1'b0, 18'h0, 1'b1, 1'b0, 12'h0); void'(exp_q.pop_front());
        check("pre_flush.req", 32'(inst_req_o), 32'd1);

        // flush while a fetch is outstanding: next ack is stale
        step(1'b0, 18'h0, 1'b0, 1'b1, 12'h3F0); exp_q.delete();
        check("flush.level", 32'(level_o),    32'd0);
        check("flush.adr",   32'(inst_adr_o), 32'h3F0);
        check("flush.req",   32'(inst_req_o), 32'd1);
        check_head("flush");
        step(1'b1, 18'h3FFFF, 1'b0, 1'b0, 12'h0);
        check("drop.level", 32'(level_o),    32'd0);
        check("drop.adr",   32'(inst_adr_o), 32'h3F0);
        check_head("drop");
        step(1'b1, 18'h05A5A, 1'b0, 1'b0, 12'h0); exp_q.push_back(18'h05A5A);
        check("after_drop.level", 32'(level_o),    32'd1);
        check("after_drop.adr",   32'(inst_adr_o), 32'h3F1);
        check_head("after_drop");

        // flush coinciding with an ack: ack discarded, nothing left in flight
        step(1'b1, 18'h00777, 1'b0, 1'b1, 12'hFFF); exp_q.delete();
        check("flush_ack.level", 32'(level_o),    32'd0);
        check("flush_ack.adr",   32'(inst_adr_o), 32'hFFF);
        step(1'b1, 18'h01234, 1'b0, 1'b0, 12'h0); exp_q.push_back(18'h01234);
        check("wrap.adr",   32'(inst_adr_o), 32'h000);
        check("wrap.level", 32'(level_o),    32'd1);
        check_head("wrap");

        // a second flush while drop is pending keeps the drop armed
        step(1'b0, 18'h0, 1'b0, 1'b1, 12'h100); exp_q.delete();
        step(1'b0, 18'h0, 1'b0, 1'b1, 12'h200);
        check("reflush.adr", 32'(inst_adr_o), 32'h200);
        step(1'b1, 18'h3FFFF, 1'b0, 1'b0, 12'h0);
        check("redrop.level", 32'(level_o),    32'd0);
        check("redrop.adr",   32'(inst_adr_o), 32'h200);
        step(1'b1, 18'h2ABCD, 1'b0, 1'b0, 12'h0); exp_q.push_back(18'h2ABCD);
        check("after_redrop.adr", 32'(inst_adr_o), 32'h201);
        check_head("after_redrop");

        // same-cycle visibility of an ack into an empty queue
        step(1'b0, 18'h0, 1'b1, 1'b0, 12'h0); void'(exp_q.pop_front());
        set_inputs(1'b1, 18'h0C0F0, 1'b0, 1'b0, 12'h0);
        #1;
`ifdef IR_BYPASS_EN
        check("bypass.valid", 32'(valid_o), 32'd1);
        check("bypass.immed", 32'(immed_o), 32'hF0);
`else
        check("bypass.valid", 32'(valid_o), 32'd0);
        check("bypass.immed", 32'(immed_o), 32'h00);
`endif
        @(posedge clk_i);
        #1;
        set_inputs(1'b0, 18'h0, 1'b0, 1'b0, 12'h0);
        #1;
        exp_q.push_back(18'h0C0F0);
        check("bypass_next.level", 32'(level_o), 32'd1);
        check_head("bypass_next");

        rst_i = 1'b1;
        step(1'b0, 18'h0, 1'b0, 1'b0, 12'h0); exp_q.delete();
        check("rerst.level", 32'(level_o),    32'd0);
        check("rerst.adr",   32'(inst_adr_o), 32'h000);
        check("rerst.req",   32'(inst_req_o), 32'd0);
        check_head("rerst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
